// File: rtl/perf_counter_bank.sv
// Per-channel event counters with a cycle watchdog, dumped one channel per beat after halt/timeout.
// Latency: counters update on the counting edge; dump_data is a combinational read of cnt[dump_idx].
// Backpressure: dump_ready=0 holds dump_idx/dump_data stable; PERF_SATURATE_EN selects saturate vs wrap.
module perf_counter_bank #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter int unsigned CYC_LIMIT = 100000,
    localparam int         IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] ev,
    input  logic              halt,
    input  logic              dump_ready,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [NUM_CH-1:0] ovf,
    output logic              timeout,
    output logic              dump_valid,
    output logic [IDX_W-1:0]  dump_idx,
    output logic [CNT_W-1:0]  dump_data,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DUMP = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(CYC_LIMIT);
    localparam logic             LIMIT_ON = (CYC_LIMIT != 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_d [NUM_CH];
    logic [NUM_CH-1:0]  ovf_q, ovf_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   dump_idx_q, dump_idx_d;
    logic               counting;
    logic               limit_hit;

    // Wrapping or saturating increment; the caller flags overflow when v is all ones.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_SATURATE_EN
        return (v == '1) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        timeout_d   = timeout_q;
        dump_idx_d  = dump_idx_q;

        counting  = ((state_q == S_IDLE) || (state_q == S_RUN)) && en;
        limit_hit = LIMIT_ON && counting && (bump(cycle_cnt_q) == LIMIT);

        if (counting) begin
            cycle_cnt_d = bump(cycle_cnt_q);
            for (int i = 0; i < NUM_CH; i++) begin
                if (ev[i]) begin
                    cnt_d[i] = bump(cnt_q[i]);
                    if (cnt_q[i] == '1) begin
                        ovf_d[i] = 1'b1;
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d   = limit_hit ? S_DUMP : S_RUN;
                    timeout_d = limit_hit;
                end
            end
            S_RUN: begin
                // halt wins over the watchdog so a requested stop is never reported as a timeout
                if (halt) begin
                    state_d = S_DUMP;
                end else if (limit_hit) begin
                    state_d   = S_DUMP;
                    timeout_d = 1'b1;
                end
            end
            S_DUMP: begin
                if (dump_ready) begin
                    if (dump_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        dump_idx_d = dump_idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            ovf_q       <= '0;
            timeout_q   <= 1'b0;
            dump_idx_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            ovf_q       <= ovf_d;
            timeout_q   <= timeout_d;
            dump_idx_q  <= dump_idx_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Index compare instead of a direct array index keeps NUM_CH=1 and non-power-of-two counts clean.
    always_comb begin
        dump_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (IDX_W'(i) == dump_idx_q) begin
                dump_data = cnt_q[i];
            end
        end
    end

    assign state      = state_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign ovf        = ovf_q;
    assign timeout    = timeout_q;
    assign dump_valid = (state_q == S_DUMP);
    assign dump_idx   = dump_idx_q;
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 4-bit instance without watchdog and an 8-bit instance
// with CYC_LIMIT=20 share stimulus; expected dump beats are queued from a counting model.
module tb_perf_counter_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       halt = 1'b0;
    logic       dump_ready = 1'b0;
    logic [3:0] ev = 4'b0;

    logic [1:0] st_a, st_b;
    logic [3:0] cyc_a, ovf_a, ovf_b, dd_a;
    logic [7:0] cyc_b, dd_b;
    logic [1:0] di_a, di_b;
    logic       to_a, to_b, dv_a, dv_b, done_a, done_b;

    int vectors = 0;
    int miscompares = 0;
    int m_cnt [4];
    int m_cyc;
    int m_st;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .CYC_LIMIT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .ev(ev), .halt(halt), .dump_ready(dump_ready),
        .state(st_a), .cycle_cnt(cyc_a), .ovf(ovf_a), .timeout(to_a), .dump_valid(dv_a),
        .dump_idx(di_a), .dump_data(dd_a), .done(done_a)
    );

    perf_counter_bank #(.NUM_CH(4), .CNT_W(8), .CYC_LIMIT(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .ev(ev), .halt(halt), .dump_ready(dump_ready),
        .state(st_b), .cycle_cnt(cyc_b), .ovf(ovf_b), .timeout(to_b), .dump_valid(dv_b),
        .dump_idx(di_b), .dump_data(dd_b), .done(done_b)
    );

    function automatic int fold(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (v <= mx) return v;
`ifdef PERF_SATURATE_EN
        return mx;
`else
        return v % (mx + 1);
`endif
    endfunction

    function automatic logic [3:0] exp_ovf(input int w);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i] = (m_cnt[i] > (1 << w) - 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; ev = 4'b0; halt = 1'b0; dump_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_cyc = 0;
        m_st  = 0;
        qa.delete();
        qb.delete();
    endtask

    // One clock with the given inputs; the model mirrors instance A (no watchdog).
    task automatic step(input logic e, input logic [3:0] v, input logic h);
        @(negedge clk);
        en = e; ev = v; halt = h;
        @(posedge clk);
        #1;
        if ((m_st == 0 || m_st == 1) && e) begin
            m_cyc++;
            for (int i = 0; i < 4; i++) if (v[i]) m_cnt[i]++;
        end
        if (m_st == 0 && e) m_st = 1;
        else if (m_st == 1 && h) m_st = 2;
    endtask

    task automatic drain(input logic b_too, input int stall_idx);
        logic [15:0] e;
        int stalls;
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            qa.push_back({8'(i), 8'(fold(m_cnt[i], 4))});
            if (b_too) qb.push_back({8'(i), 8'(fold(m_cnt[i], 8))});
        end
        en = 1'b0; ev = 4'b0; halt = 1'b0;
        for (int c = 0; c < 40 && (qa.size() != 0 || qb.size() != 0); c++) begin
            @(negedge clk);
            if (dv_a && int'(di_a) == stall_idx && stalls < 3 && qa.size() != 0) begin
                dump_ready = 1'b0;
                stalls++;
                chk("stall_data", 32'(dd_a), 32'(qa[0][7:0]));
                chk("stall_valid", 32'(dv_a), 32'd1);
            end else begin
                dump_ready = 1'b1;
                #1;
                if (dv_a && qa.size() != 0) begin
                    e = qa.pop_front();
                    chk("beat_a_idx", 32'(di_a), 32'(e[15:8]));
                    chk("beat_a_data", 32'(dd_a), 32'(e[7:0]));
                end
                if (dv_b && qb.size() != 0) begin
                    e = qb.pop_front();
                    chk("beat_b_idx", 32'(di_b), 32'(e[15:8]));
                    chk("beat_b_data", 32'(dd_b), 32'(e[7:0]));
                end
            end
            @(posedge clk);
            #1;
        end
        dump_ready = 1'b0;
        if (qa.size() != 0 || qb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout observed=%0d/%0d beats left expected=0", qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        if (stall_idx >= 0) chk("stall_count", 32'(stalls), 32'd3);
        m_st = 3;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_state_a", 32'(st_a), 32'd0);
        chk("rst_state_b", 32'(st_b), 32'd0);
        chk("rst_cyc_a", 32'(cyc_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_timeout_b", 32'(to_b), 32'd0);
        chk("rst_valid_a", 32'(dv_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);

        // Basic counting, halt edge counts its own events, then a full dump
        for (int k = 0; k < 10; k++) step(1'b1, 4'b0101, 1'b0);
        chk("run_state_a", 32'(st_a), 32'd1);
        step(1'b1, 4'b0001, 1'b1);
        chk("halt_state_a", 32'(st_a), 32'd2);
        chk("halt_state_b", 32'(st_b), 32'd2);
        chk("halt_cyc_a", 32'(cyc_a), 32'(fold(m_cyc, 4)));
        chk("halt_cyc_b", 32'(cyc_b), 32'd11);
        chk("halt_timeout_b", 32'(to_b), 32'd0);
        drain(1'b1, -1);
        chk("done_a", 32'(done_a), 32'd1);
        chk("done_state_b", 32'(st_b), 32'd3);
        chk("done_valid_a", 32'(dv_a), 32'd0);
        step(1'b1, 4'b1111, 1'b1);
        chk("done_hold_state", 32'(st_a), 32'd3);
        chk("done_hold_cyc_b", 32'(cyc_b), 32'd11);

        // Counter overflow on the 4-bit instance, with a 3-cycle stall at idx 2
        do_reset();
        for (int k = 0; k < 17; k++) step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0000, 1'b1);
        chk("ovf_a", 32'(ovf_a), 32'(exp_ovf(4)));
        chk("ovf_a_const", 32'(ovf_a), 32'b0010);
        chk("ovf_b", 32'(ovf_b), 32'd0);
        chk("ovf_cyc_a", 32'(cyc_a), 32'(fold(m_cyc, 4)));
        drain(1'b1, 2);

        // en=0 pause freezes everything; halt still honoured while paused
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 4'b1111, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 4'b1111, 1'b0);
        chk("pause_cyc_a", 32'(cyc_a), 32'd3);
        chk("pause_state_a", 32'(st_a), 32'd1);
        step(1'b0, 4'b1111, 1'b1);
        chk("pause_halt_state", 32'(st_a), 32'd2);
        drain(1'b1, -1);

        // Watchdog on instance B
        do_reset();
        for (int k = 0; k < 19; k++) step(1'b1, 4'b0000, 1'b0);
        chk("wd_pre_state_b", 32'(st_b), 32'd1);
        chk("wd_pre_timeout_b", 32'(to_b), 32'd0);
        step(1'b1, 4'b0000, 1'b0);
        chk("wd_state_b", 32'(st_b), 32'd2);
        chk("wd_cyc_b", 32'(cyc_b), 32'd20);
        chk("wd_timeout_b", 32'(to_b), 32'd1);
        chk("wd_state_a", 32'(st_a), 32'd1);
        chk("wd_cyc_a", 32'(cyc_a), 32'(fold(m_cyc, 4)));
        step(1'b1, 4'b1111, 1'b0);
        chk("wd_frozen_cyc_b", 32'(cyc_b), 32'd20);

        // halt on the watchdog edge suppresses timeout
        do_reset();
        for (int k = 0; k < 19; k++) step(1'b1, 4'b0001, 1'b0);
        step(1'b1, 4'b0001, 1'b1);
        chk("wdh_state_b", 32'(st_b), 32'd2);
        chk("wdh_timeout_b", 32'(to_b), 32'd0);
        chk("wdh_cyc_b", 32'(cyc_b), 32'd20);
        chk("wdh_data_b", 32'(dd_b), 32'd20);
        chk("wdh_data_a", 32'(dd_a), 32'(fold(m_cnt[0], 4)));

        // Reset mid-dump at idx 1
        @(negedge clk);
        en = 1'b0; ev = 4'b0; halt = 1'b0; dump_ready = 1'b1;
        @(posedge clk);
        #1;
        dump_ready = 1'b0;
        chk("mid_idx_a", 32'(di_a), 32'd1);
        chk("mid_idx_b", 32'(di_b), 32'd1);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; ev = 4'b1111; halt = 1'b1; dump_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_state_a", 32'(st_a), 32'd0);
        chk("abort_state_b", 32'(st_b), 32'd0);
        chk("abort_valid_a", 32'(dv_a), 32'd0);
        chk("abort_valid_b", 32'(dv_b), 32'd0);
        chk("abort_cyc_b", 32'(cyc_b), 32'd0);
        chk("abort_ovf_a", 32'(ovf_a), 32'd0);
        chk("abort_idx_b", 32'(di_b), 32'd0);
        chk("abort_data_b", 32'(dd_b), 32'd0);
        chk("abort_data_a", 32'(dd_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; ev = 4'b0; halt = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_valid_a", 32'(dv_a), 32'd0);
        chk("post_abort_state_a", 32'(st_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of event channels, 1..16.
REQ-002 Parameter CNT_W, default 32: width of every counter, 4..32.
REQ-003 Parameter CYC_LIMIT, default 100000: run-cycle watchdog limit; 0 disables the watchdog; must be at most 2^CNT_W-1.
REQ-004 IDX_W SHALL be max(1, clog2(NUM_CH)).
REQ-005 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  count enable.
REQ-008 ev  in  NUM_CH  per-channel event strobe, one count per cycle high.
REQ-009 halt  in  1  stop counting and begin the dump.
REQ-010 dump_ready  in  1  consumer accepts the current dump beat.
REQ-011 state  out  2  IDLE=00, RUN=01, DUMP=10, DONE=11.
REQ-012 cycle_cnt  out  CNT_W  number of enabled RUN cycles.
REQ-013 ovf  out  NUM_CH  sticky per-channel overflow flag.
REQ-014 timeout  out  1  sticky flag; the watchdog ended the run.
REQ-015 dump_valid  out  1  dump beat is valid.
REQ-016 dump_idx  out  IDX_W  channel index of the current dump beat.
REQ-017 dump_data  out  CNT_W  counter value of channel dump_idx.
REQ-018 done  out  1  dump complete; high only in DONE.

Function
REQ-019 IDLE SHALL go to RUN on the first edge with en=1; that edge SHALL also count the cycle and the ev inputs.
REQ-020 In RUN with en=1, each edge SHALL increment cycle_cnt by 1 and increment cnt[i] by 1 for each ev[i]=1.
REQ-021 In RUN with en=0, all counters SHALL hold; halt SHALL still be honoured.
REQ-022 Any events present in the cycle where halt=1 SHALL be counted (when en=1), and the state SHALL then go to DUMP.
REQ-023 When CYC_LIMIT≠0 and an increment makes cycle_cnt equal CYC_LIMIT, the state SHALL go to DUMP and timeout SHALL be set.
REQ-024 If halt and the limit occur on the same edge, halt has priority and timeout SHALL stay 0.
REQ-025 In DUMP and DONE, all counters SHALL be frozen and ev, en and halt SHALL be ignored.
REQ-026 In DUMP, dump_valid SHALL be 1 and dump_idx SHALL start at 0.
REQ-027 dump_data SHALL equal cnt[dump_idx] with no extra latency.
REQ-028 On each edge with dump_valid and dump_ready both 1, dump_idx SHALL advance by 1.
REQ-029 When the beat with dump_idx=NUM_CH-1 is accepted, the state SHALL go to DONE.
REQ-030 While dump_ready=0, dump_idx and dump_data SHALL hold stable.
REQ-031 DONE SHALL persist until reset, with done=1 and dump_valid=0.
REQ-032 Overflow on increment: the counter wraps to 0 and ovf[i] is set; see REQ-037 for the alternative.
REQ-033 cycle_cnt SHALL follow the same overflow rule but has no flag.

Reset
REQ-034 With rst_n=0 at an edge, the block SHALL enter IDLE.
REQ-035 That reset SHALL clear all counters, ovf, timeout, dump_idx, dump_valid and done, and SHALL override every other input.
REQ-036 Reset in any state, including mid-dump, SHALL abort the operation, and no beat SHALL be emitted on the following cycle.

Configuration
REQ-037 With PERF_SATURATE_EN defined, counters SHALL saturate at 2^CNT_W-1 instead of wrapping, and ovf[i] SHALL still be set on the first attempted overflow.
REQ-038 With PERF_SATURATE_EN undefined, counters SHALL wrap modulo 2^CNT_W.

Verification
REQ-039 NUM_CH=4, CNT_W=8: en=1 and ev=0101 for 10 cycles, then ev=0001 with halt -> dump beats (0,11), (1,0), (2,10), (3,0), then done=1 and cycle_cnt=11.
REQ-040 CNT_W=4: ev[1]=1 for 17 cycles then halt -> cnt1=1 and ovf=0010; with PERF_SATURATE_EN, cnt1=15 and ovf=0010.
REQ-041 CYC_LIMIT=20, en=1, no halt -> state=DUMP after the 20th RUN edge with cycle_cnt=20 and timeout=1; halt on that same edge -> timeout=0.
REQ-042 In DUMP, dump_ready=0 for 3 cycles at dump_idx=2 -> dump_valid=1 and idx/data unchanged, then idx=3 one edge after ready rises.
REQ-043 en=0 for 5 cycles mid-RUN with ev=1111 -> counters unchanged; halt during the pause -> DUMP.
REQ-044 rst_n=0 during DUMP at dump_idx=1 -> next cycle state=IDLE, dump_valid=0, all counters 0 and ovf 0.
